// File: rtl/wb_slave_mux_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_slave_mux_ctrl_pkg
// Brief    : Shared state encoding and decode constants for the Wishbone
//            slave mux controller.
// Revision : 1.0
// ============================================================================
package wb_slave_mux_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_LOCAL = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [3:0]  SLOT_LOCAL = 4'hF;
    localparam int          NSLV       = 4;
    localparam logic [31:0] ERR_DATA   = 32'hDEAD_BEEF;

endpackage
`default_nettype wire

// File: rtl/wb_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module   : wb_timeout_ctr
// Brief    : Loadable wait counter; o_tc flags that TIMEOUT cycles have elapsed.
// Revision : 1.0
// ============================================================================
module wb_timeout_ctr #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_tc
);

    localparam int             c_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_W-1:0] c_LOAD = c_W'(1);
    localparam logic [c_W-1:0] c_TERM = c_W'(TIMEOUT);
    localparam logic [c_W-1:0] c_ONE  = c_W'(1);

    logic [c_W-1:0] r_cnt;

    // Loading 1 makes the count equal the number of strobe cycles already shown.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= c_LOAD;
        end else if (i_en && (r_cnt != c_TERM)) begin
            r_cnt <= r_cnt + c_ONE;
        end
    end

    assign o_tc = (r_cnt == c_TERM);

endmodule
`default_nettype wire

// File: rtl/wb_slave_mux_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : wb_slave_mux_ctrl
// Brief    : Wishbone classic 1-to-4 slave mux with timeout, local status
//            register and interrupt aggregation.
// Revision : 1.0
// ============================================================================
module wb_slave_mux_ctrl
    import wb_slave_mux_ctrl_pkg::*;
#(
    parameter int         TIMEOUT = 255,
    parameter logic [7:0] BASE_HI = 8'h30
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          wbs_cyc_i,
    input  logic          wbs_stb_i,
    input  logic          wbs_we_i,
    input  logic [3:0]    wbs_sel_i,
    input  logic [31:0]   wbs_adr_i,
    input  logic [31:0]   wbs_dat_i,
    output logic          wbs_ack_o,
    output logic [31:0]   wbs_dat_o,
    output logic [3:0]    s_cyc_o,
    output logic [3:0]    s_stb_o,
    output logic          s_we_o,
    output logic [3:0]    s_sel_o,
    output logic [31:0]   s_adr_o,
    output logic [31:0]   s_dat_o,
    input  logic [127:0]  s_dat_i,
    input  logic [3:0]    s_ack_i,
    input  logic [3:0]    irq_i,
    output logic [2:0]    irq_o
);

    state_t            r_state;
    state_t            w_state_nxt;

    logic [31:0]       r_adr;
    logic [31:0]       r_dat;
    logic [3:0]        r_sel;
    logic              r_we;
    logic [1:0]        r_slot;

    logic [NSLV-1:0]   r_strobe;
    logic [NSLV-1:0]   w_strobe_nxt;
    logic              r_ack;
    logic              w_ack_nxt;
    logic [31:0]       r_dat_o;
    logic [31:0]       w_dat_nxt;

    logic [7:0]        r_err_cnt;
    logic              r_to_pend;
    logic [1:0]        r_irq_pair;

    logic              w_accept;
    logic              w_ctr_load;
    logic              w_ctr_en;
    logic              w_tc;
    logic              w_to_set;
    logic              w_err_inc;
    logic              w_stat_clr;

    logic [3:0]        w_slot_dec;
    logic              w_base_hit;
    logic              w_slv_hit;
    logic              w_local_hit;
    logic              w_sel_ack;
    logic [31:0]       w_sel_dat;
    logic [31:0]       w_status;

    assign w_slot_dec  = wbs_adr_i[23:20];
    assign w_base_hit  = (wbs_adr_i[31:24] == BASE_HI);
    assign w_slv_hit   = w_base_hit && (w_slot_dec < 4'(NSLV));
    assign w_local_hit = w_base_hit && (w_slot_dec == SLOT_LOCAL);
    assign w_sel_ack   = s_ack_i[r_slot];
    assign w_sel_dat   = s_dat_i[{r_slot, 5'd0} +: 32];
    assign w_status    = {16'h0, 7'h0, r_to_pend, r_err_cnt};

    wb_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .i_load (w_ctr_load),
        .i_en   (w_ctr_en),
        .o_tc   (w_tc)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_strobe_nxt = r_strobe;
        w_ack_nxt    = 1'b0;
        w_dat_nxt    = '0;
        w_accept     = 1'b0;
        w_ctr_load   = 1'b0;
        w_ctr_en     = 1'b0;
        w_to_set     = 1'b0;
        w_err_inc    = 1'b0;
        w_stat_clr   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    w_accept   = 1'b1;
                    w_ctr_load = 1'b1;
                    if (w_slv_hit) begin
                        w_state_nxt  = ST_BUSY;
                        w_strobe_nxt = 4'b0001 << wbs_adr_i[21:20];
                    end else if (w_local_hit) begin
                        w_state_nxt = ST_LOCAL;
                    end else begin
                        w_state_nxt = ST_RESP;
                        w_ack_nxt   = 1'b1;
                        w_dat_nxt   = ERR_DATA;
                    end
                end
            end

            // A master abort outranks a same-cycle ack or timeout.
            ST_BUSY: begin
                w_ctr_en = 1'b1;
                if (!wbs_cyc_i) begin
                    w_state_nxt  = ST_IDLE;
                    w_strobe_nxt = '0;
                end else if (w_sel_ack) begin
                    w_state_nxt  = ST_RESP;
                    w_strobe_nxt = '0;
                    w_ack_nxt    = 1'b1;
                    w_dat_nxt    = w_sel_dat;
                end else if (w_tc) begin
                    w_state_nxt  = ST_RESP;
                    w_strobe_nxt = '0;
                    w_ack_nxt    = 1'b1;
                    w_dat_nxt    = ERR_DATA;
                    w_to_set     = 1'b1;
                    w_err_inc    = 1'b1;
                end
            end

            ST_LOCAL: begin
                w_state_nxt = ST_RESP;
                w_ack_nxt   = 1'b1;
                if (r_we) begin
                    w_stat_clr = r_sel[0];
                end else begin
                    w_dat_nxt = w_status;
                end
            end

            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt  = ST_IDLE;
                w_strobe_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_adr      <= '0;
            r_dat      <= '0;
            r_sel      <= '0;
            r_we       <= 1'b0;
            r_slot     <= '0;
            r_strobe   <= '0;
            r_ack      <= 1'b0;
            r_dat_o    <= '0;
            r_err_cnt  <= '0;
            r_to_pend  <= 1'b0;
            r_irq_pair <= '0;
        end else begin
            if (w_accept) begin
                r_adr  <= wbs_adr_i;
                r_dat  <= wbs_dat_i;
                r_sel  <= wbs_sel_i;
                r_we   <= wbs_we_i;
                r_slot <= wbs_adr_i[21:20];
            end
            r_strobe   <= w_strobe_nxt;
            r_ack      <= w_ack_nxt;
            r_dat_o    <= w_dat_nxt;
            r_irq_pair <= {irq_i[2] | irq_i[3], irq_i[0] | irq_i[1]};

            // A new timeout wins over a simultaneous status clear.
            if (w_err_inc) begin
                if (r_err_cnt != 8'hFF) begin
                    r_err_cnt <= r_err_cnt + 8'd1;
                end
            end else if (w_stat_clr) begin
                r_err_cnt <= '0;
            end

            if (w_to_set) begin
                r_to_pend <= 1'b1;
            end else if (w_stat_clr) begin
                r_to_pend <= 1'b0;
            end
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat_o;
    assign s_cyc_o   = r_strobe;
    assign s_stb_o   = r_strobe;
    assign s_we_o    = r_we;
    assign s_sel_o   = r_sel;
    assign s_adr_o   = r_adr;
    assign s_dat_o   = r_dat;
    assign irq_o     = {r_to_pend, r_irq_pair};

endmodule
`default_nettype wire
